// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared FSM encodings and data widths for the AES decryptor arbiter
package aes_dec_pkg;

   localparam int AES_BLK_W = 128;
   localparam int AES_SEL_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set request at or after ptr
module rr_priority_pick
   import aes_dec_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] owner,
   output logic             any_valid
);

   // Walk offsets from far to near so the nearest hit to ptr is the one that sticks.
   always_comb begin
      int                j;
      logic [IDX_W-1:0]  idx;
      owner     = '0;
      any_valid = 1'b0;
      j         = 0;
      idx       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         idx = IDX_W'(j);
         if (req[idx]) begin
            owner     = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_dec_arbiter.sv
// rtl/aes_dec_arbiter.sv - round-robin sharing of one AES decryptor core among N_REQ requesters
// Optional RUN watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_dec_arbiter
   import aes_dec_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [N_REQ-1:0]             Req,
   input  logic [AES_BLK_W*N_REQ-1:0]   ReqCT,
   input  logic [AES_BLK_W*N_REQ-1:0]   ReqKey,
   output logic [AES_SEL_W-1:0]         KeySel,
   output logic [N_REQ-1:0]             Ack,
   output logic [AES_BLK_W-1:0]         PtOut,
   output logic                         Busy,
   output logic                         Err,
   output logic                         DecEn,
   output logic [AES_BLK_W-1:0]         DecCT,
   output logic [AES_BLK_W-1:0]         DecKey,
   input  logic [AES_SEL_W-1:0]         DecSelKey,
   input  logic                         DecRy,
   input  logic [AES_BLK_W-1:0]         DecPT
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [1:0]       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pick_owner;
   logic             pick_valid;

   rr_priority_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req       (Req),
      .ptr       (ptr),
      .owner     (pick_owner),
      .any_valid (pick_valid)
   );

`ifdef AES_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] timer;
   logic             err_flag;
`else
   // TIMEOUT has no effect without the watchdog; a non-positive value is simply ignored.
   if (TIMEOUT < 1) begin : g_timeout_unused
   end
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= ST_IDLE;
         owner <= '0;
         ptr   <= '0;
         DecEn <= 1'b0;
         DecCT <= '0;
         PtOut <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         timer    <= '0;
         err_flag <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner <= pick_owner;
                  DecCT <= ReqCT[int'(pick_owner)*AES_BLK_W +: AES_BLK_W];
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               DecEn <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
               timer    <= '0;
               err_flag <= 1'b0;
`endif
               state <= ST_RUN;
            end
            ST_RUN: begin
`ifdef AES_ARB_TIMEOUT_EN
               timer <= timer + 1'b1;
`endif
               if (DecRy) begin
                  PtOut <= DecPT;
                  DecEn <= 1'b0;
                  state <= ST_DONE;
               end
`ifdef AES_ARB_TIMEOUT_EN
               else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  PtOut    <= '0;
                  DecEn    <= 1'b0;
                  err_flag <= 1'b1;
                  state    <= ST_DONE;
               end
`endif
            end
            default: begin
               ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      Ack = '0;
      if (state == ST_DONE) Ack[owner] = 1'b1;
   end

   assign Busy   = (state != ST_IDLE);
   assign KeySel = DecSelKey;
   assign DecKey = ReqKey[int'(owner)*AES_BLK_W +: AES_BLK_W];

`ifdef AES_ARB_TIMEOUT_EN
   assign Err = err_flag && (state == ST_DONE);
`else
   assign Err = 1'b0;
`endif

endmodule
